pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the RV32IM pipeline's IF stage. Holds the fetch PC and selects the next PC: sequential increment, branch/jump redirect or trap redirect. Redirects that arrive while the front end is stalled are captured and applied when the stall clears, never dropped. A short post-reset boot hold and a fetch-valid qualifier drive the instruction memory interface.

## Interface
- XLEN, 32, PC width in bits (≥ 8)
- RESET_VECTOR, 0, PC value loaded on reset
- INC, 4, sequential increment in bytes
- BOOT_CYCLES, 1, cycles FETCH_VALID stays low after reset release (0 allowed)

Ports:
- CLOCK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- BUSYWAIT  in  1  instruction memory stall
- STALL  in  1  hazard-unit stall
- BRANCH_TAKEN  in  1  branch/jump redirect request (EX stage)
- BRANCH_TARGET  in  XLEN  redirect address
- TRAP  in  1  trap/exception redirect request
- TRAP_VECTOR  in  XLEN  trap handler address
- PC  out  XLEN  current fetch address
- PC_PLUS_INC  out  XLEN  PC + INC (combinational, modulo 2^XLEN)
- FETCH_VALID  out  1  PC is a valid fetch request this cycle
- MISALIGN  out  1  one-cycle pulse: an applied target had bits[1:0] ≠ 0

## Operation
- HOLD = BUSYWAIT | STALL.
- Next-PC priority: TRAP > BRANCH_TAKEN > pending redirect > PC + INC.
- Target used: the selected address with bits[1:0] forced to 0.
- MISALIGN pulses on the cycle after a target with nonzero bits[1:0] is applied to PC.
- Pending register (PEND_V, PEND_ADDR):
  - Captured when HOLD = 1 and TRAP or BRANCH_TAKEN is asserted.
  - A later TRAP during the hold overwrites a pending branch.
  - A later branch does not overwrite a pending trap.
  - A later branch overwrites a pending branch.
  - Cleared when applied.
- FSM states: BOOT, RUN, HOLD.
  - BOOT: PC = RESET_VECTOR, FETCH_VALID = 0, internal counter runs for BOOT_CYCLES. Go to RUN, or to HOLD if HOLD = 1. With BOOT_CYCLES = 0, enter RUN directly on reset release.
  - RUN: FETCH_VALID = 1. If HOLD = 1, go to HOLD and PC is unchanged. If HOLD = 0, PC ← next PC.
  - HOLD: FETCH_VALID = 1 and PC is held (request stays stable for imem). Capture redirects into the pending register. When HOLD falls, go to RUN and apply the next PC using the same priority; the pending redirect beats increment.
- A redirect during BOOT is ignored. The IF stage holds no valid instruction then.
- PC wraps modulo 2^XLEN; no overflow flag.

## Timing
- Reset values (asynchronous, immediate): PC = RESET_VECTOR, FETCH_VALID = 0, MISALIGN = 0, PEND_V = 0, state = BOOT.
- Redirect latency: when TRAP or BRANCH_TAKEN is sampled at edge N with HOLD = 0, PC = target after edge N.
- Held redirect: PC = target after the first edge at which HOLD = 0.
- Simultaneous redirect and HOLD falling in the same cycle: the live request beats the pending one, and the pending register is cleared.
- Reset asserted mid-hold: the pending register is discarded.
- All outputs except PC_PLUS_INC are registered.

## Structure
- Shared package `pc_pkg`: state enum (BOOT/RUN/HOLD), next-PC select encoding, alignment mask constant.
- One natural sub-module: `pc_redirect_latch` (pending register with trap-over-branch priority).
- The top level keeps the FSM, boot counter and PC register.

## Test plan
- Reset with RESET_VECTOR = 0x100 and BOOT_CYCLES = 2 -> PC = 0x100 and FETCH_VALID = 0 for 2 cycles, then PC steps 0x104, 0x108 with FETCH_VALID = 1.
- BRANCH_TAKEN with target 0x2000 and HOLD = 0 -> PC = 0x2000 after one edge, then 0x2004.
- BRANCH_TAKEN with target 0x3000 during BUSYWAIT for 3 cycles -> PC frozen for 3 cycles, then 0x3000 on the first unstalled edge.
- During STALL: branch to 0x40, then TRAP to 0x80 -> PC becomes 0x80. Reversed order (trap, then branch) -> also 0x80.
- Target 0x1006 -> PC = 0x1004, with MISALIGN pulsing for exactly one cycle.
- XLEN = 8 with PC = 0xFC -> PC wraps to 0x00. Reset asserted during HOLD with a pending redirect -> PC = RESET_VECTOR, and the pending redirect is not applied after release.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit
package pc_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HOLD} pc_state_e;
  typedef enum logic [1:0] {SEL_INC, SEL_PEND, SEL_BR, SEL_TRAP} pc_sel_e;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: pipeline-side request/response bundle of the program-counter unit
interface pc_unit_if #(parameter int XLEN = 32);
  logic BUSYWAIT, STALL, BRANCH_TAKEN, TRAP, FETCH_VALID, MISALIGN;
  logic [XLEN-1:0] BRANCH_TARGET, TRAP_VECTOR, PC, PC_PLUS_INC;
  modport master(output BUSYWAIT, STALL, BRANCH_TAKEN, BRANCH_TARGET, TRAP, TRAP_VECTOR,
                 input PC, PC_PLUS_INC, FETCH_VALID, MISALIGN);
  modport slave(input BUSYWAIT, STALL, BRANCH_TAKEN, BRANCH_TARGET, TRAP, TRAP_VECTOR,
                output PC, PC_PLUS_INC, FETCH_VALID, MISALIGN);
endinterface

// File: rtl/pc_redirect_latch.sv
// pc_redirect_latch: holds one redirect captured during a stall, traps outranking branches
module pc_redirect_latch #(
  parameter int XLEN = 32
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            cap,
  input  logic            clr,
  input  logic            trap,
  input  logic            branch,
  input  logic [XLEN-1:0] trap_vector,
  input  logic [XLEN-1:0] branch_target,
  output logic            pend_v,
  output logic [XLEN-1:0] pend_addr
);
  logic pend_trap;
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      pend_v <= 1'b0;
      pend_trap <= 1'b0;
      pend_addr <= '0;
    end else if (clr) begin
      pend_v <= 1'b0;
      pend_trap <= 1'b0;
    end else if (cap && trap) begin
      pend_v <= 1'b1;
      pend_trap <= 1'b1;
      pend_addr <= trap_vector;
    end else if (cap && branch && !(pend_v && pend_trap)) begin
      pend_v <= 1'b1;
      pend_trap <= 1'b0;
      pend_addr <= branch_target;
    end
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: IF-stage fetch PC with boot hold, stall-safe redirects and misalignment flag
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 4,
  parameter int              BOOT_CYCLES  = 1
) (
  input logic CLOCK,
  input logic RESET,
  pc_unit_if.slave bus
);
  localparam int CW = BOOT_CYCLES > 1 ? $clog2(BOOT_CYCLES) : 1;
  localparam pc_state_e INIT = BOOT_CYCLES == 0 ? RUN : BOOT;
  pc_state_e state;
  pc_sel_e sel;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] pc, raw, next_pc, pend_addr, pc_plus;
  logic fv, mis, pend_v, hold, active, redirect;
  assign hold = bus.BUSYWAIT | bus.STALL;
  assign active = state != BOOT;
  assign sel = bus.TRAP ? SEL_TRAP : bus.BRANCH_TAKEN ? SEL_BR : pend_v ? SEL_PEND : SEL_INC;
  assign raw = sel == SEL_TRAP ? bus.TRAP_VECTOR : sel == SEL_BR ? bus.BRANCH_TARGET : pend_addr;
  assign redirect = sel != SEL_INC;
  assign pc_plus = pc + XLEN'(INC);
  assign next_pc = redirect ? raw & ~XLEN'(ALIGN_MASK) : pc_plus;
  pc_redirect_latch #(.XLEN(XLEN)) u_latch (
    .CLOCK(CLOCK), .RESET(RESET),
    .cap(active & hold), .clr(active & ~hold),
    .trap(bus.TRAP), .branch(bus.BRANCH_TAKEN),
    .trap_vector(bus.TRAP_VECTOR), .branch_target(bus.BRANCH_TARGET),
    .pend_v(pend_v), .pend_addr(pend_addr)
  );
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= INIT;
      pc <= RESET_VECTOR;
      fv <= BOOT_CYCLES == 0;
      mis <= 1'b0;
      cnt <= '0;
    end else begin
      mis <= 1'b0;
      if (state == BOOT) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(BOOT_CYCLES - 1)) begin
          fv <= 1'b1;
          state <= hold ? HOLD : RUN;
        end
      end else begin
        state <= hold ? HOLD : RUN;
        if (!hold) begin
          pc <= next_pc;
          mis <= redirect && |(raw[1:0] & ALIGN_MASK);
        end
      end
    end
  end
  assign bus.PC = pc;
  assign bus.PC_PLUS_INC = pc_plus;
  assign bus.FETCH_VALID = fv;
  assign bus.MISALIGN = mis;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scenario and randomized checks of pc_unit against a behavioural model
module tb_pc_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  pc_unit_if #(.XLEN(32)) bus ();
  pc_unit_if #(.XLEN(8)) bus8 ();
  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .INC(4), .BOOT_CYCLES(2)) dut (
    .CLOCK(clock), .RESET(reset), .bus(bus));
  pc_unit #(.XLEN(8), .RESET_VECTOR(8'hF4), .INC(4), .BOOT_CYCLES(0)) dut8 (
    .CLOCK(clock), .RESET(reset), .bus(bus8));
  always #5 clock = ~clock;

  logic [31:0] m_pc, m_pa;
  logic m_fv, m_mis, m_pv, m_pt;
  int m_boot;

  task automatic model_reset();
    m_pc = 32'h100; m_fv = 0; m_mis = 0; m_pv = 0; m_pt = 0; m_pa = 0; m_boot = 2;
  endtask

  task automatic model_step();
    logic [31:0] t;
    bit go;
    m_mis = 0;
    t = 0;
    if (m_boot > 0) begin
      m_boot--;
      if (m_boot == 0) m_fv = 1;
    end else if (bus.BUSYWAIT || bus.STALL) begin
      if (bus.TRAP) begin m_pv = 1; m_pt = 1; m_pa = bus.TRAP_VECTOR; end
      else if (bus.BRANCH_TAKEN && !(m_pv && m_pt)) begin m_pv = 1; m_pt = 0; m_pa = bus.BRANCH_TARGET; end
    end else begin
      go = 1;
      if (bus.TRAP) t = bus.TRAP_VECTOR;
      else if (bus.BRANCH_TAKEN) t = bus.BRANCH_TARGET;
      else if (m_pv) t = m_pa;
      else go = 0;
      m_pc = go ? (t & 32'hFFFF_FFFC) : m_pc + 32'd4;
      m_mis = go && (t[1:0] != 2'b00);
      m_pv = 0;
      m_pt = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic bw, input logic st, input logic br, input logic [31:0] bt,
                       input logic tr, input logic [31:0] tv);
    bus.BUSYWAIT = bw; bus.STALL = st; bus.BRANCH_TAKEN = br; bus.BRANCH_TARGET = bt;
    bus.TRAP = tr; bus.TRAP_VECTOR = tv;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #2;
    model_reset();
    tests++; if (bus.PC !== 32'h100) begin fails++; $display("FAIL reset_pc: got %h expected %h", bus.PC, 32'h100); end
    tests++; if (bus.FETCH_VALID !== 1'b0) begin fails++; $display("FAIL reset_fv: got %b expected 0", bus.FETCH_VALID); end
    tests++; if (bus.MISALIGN !== 1'b0) begin fails++; $display("FAIL reset_mis: got %b expected 0", bus.MISALIGN); end
    reset = 1'b1;
    drive(0, 0, 1, 32'h900, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tests++; if (bus.FETCH_VALID !== 1'b0 || bus.PC !== 32'h100) begin
        fails++; $display("FAIL boot_hold: cycle %0d got fv=%b pc=%h expected fv=0 pc=00000100", i, bus.FETCH_VALID, bus.PC);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    tests++; if (bus.FETCH_VALID !== 1'b1 || bus.PC !== 32'h100) begin
      fails++; $display("FAIL boot_first_fetch: got fv=%b pc=%h expected fv=1 pc=00000100", bus.FETCH_VALID, bus.PC);
    end
    tick();
    tests++; if (bus.PC !== 32'h104) begin fails++; $display("FAIL step_104: got %h expected 00000104", bus.PC); end
    tick();
    tests++; if (bus.PC !== 32'h108) begin fails++; $display("FAIL step_108: got %h expected 00000108", bus.PC); end
  endtask

  task automatic test_branch();
    drive(0, 0, 1, 32'h2000, 0, 0);
    tick();
    tests++; if (bus.PC !== 32'h2000) begin fails++; $display("FAIL branch: got %h expected 00002000", bus.PC); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tests++; if (bus.PC !== 32'h2004) begin fails++; $display("FAIL branch_next: got %h expected 00002004", bus.PC); end
  endtask

  task automatic test_busywait_branch();
    drive(1, 0, 1, 32'h3000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1, 0, 0, 0, 0, 0);
      tests++; if (bus.PC !== 32'h2004 || bus.FETCH_VALID !== 1'b1) begin
        fails++; $display("FAIL busy_freeze: cycle %0d got pc=%h fv=%b expected pc=00002004 fv=1", i, bus.PC, bus.FETCH_VALID);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tests++; if (bus.PC !== 32'h3000) begin fails++; $display("FAIL busy_release: got %h expected 00003000", bus.PC); end
  endtask

  task automatic test_trap_priority();
    drive(0, 1, 1, 32'h40, 0, 0); tick();
    drive(0, 1, 0, 0, 1, 32'h80); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    tests++; if (bus.PC !== 32'h80) begin fails++; $display("FAIL br_then_trap: got %h expected 00000080", bus.PC); end
    drive(0, 1, 0, 0, 1, 32'h80); tick();
    drive(0, 1, 1, 32'h40, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    tests++; if (bus.PC !== 32'h80) begin fails++; $display("FAIL trap_then_br: got %h expected 00000080", bus.PC); end
  endtask

  task automatic test_misalign();
    drive(0, 0, 1, 32'h1006, 0, 0); tick();
    tests++; if (bus.PC !== 32'h1004 || bus.MISALIGN !== 1'b1) begin
      fails++; $display("FAIL misalign_pulse: got pc=%h mis=%b expected pc=00001004 mis=1", bus.PC, bus.MISALIGN);
    end
    drive(0, 0, 0, 0, 0, 0); tick();
    tests++; if (bus.PC !== 32'h1008 || bus.MISALIGN !== 1'b0) begin
      fails++; $display("FAIL misalign_end: got pc=%h mis=%b expected pc=00001008 mis=0", bus.PC, bus.MISALIGN);
    end
  endtask

  task automatic test_live_beats_pending();
    drive(0, 1, 1, 32'h500, 0, 0); tick();
    drive(0, 0, 1, 32'h600, 0, 0); tick();
    tests++; if (bus.PC !== 32'h600) begin fails++; $display("FAIL live_beats_pend: got %h expected 00000600", bus.PC); end
    drive(0, 0, 0, 0, 0, 0); tick();
    tests++; if (bus.PC !== 32'h604) begin fails++; $display("FAIL pend_cleared: got %h expected 00000604", bus.PC); end
  endtask

  task automatic test_reset_in_hold();
    drive(0, 1, 1, 32'h700, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    tests++; if (bus.PC !== 32'h100) begin fails++; $display("FAIL reset_hold_pc: got %h expected 00000100", bus.PC); end
    for (int i = 0; i < 3; i++) tick();
    tests++; if (bus.PC !== 32'h104) begin fails++; $display("FAIL pend_discarded: got %h expected 00000104", bus.PC); end
  endtask

  task automatic test_wrap();
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    tests++; if (bus8.PC !== 8'hF4) begin fails++; $display("FAIL x8_reset: got %h expected f4", bus8.PC); end
    tick(); tick();
    tests++; if (bus8.PC !== 8'hFC || bus8.PC_PLUS_INC !== 8'h00 || bus8.FETCH_VALID !== 1'b1) begin
      fails++; $display("FAIL x8_fc: got pc=%h plus=%h fv=%b expected pc=fc plus=00 fv=1", bus8.PC, bus8.PC_PLUS_INC, bus8.FETCH_VALID);
    end
    tick();
    tests++; if (bus8.PC !== 8'h00) begin fails++; $display("FAIL x8_wrap: got %h expected 00", bus8.PC); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0, $urandom,
            $urandom_range(11) == 0, $urandom);
      tick();
      tests++; if (bus.PC !== m_pc) begin fails++; $display("FAIL rand_pc: cycle %0d got %h expected %h", i, bus.PC, m_pc); end
      tests++; if (bus.PC_PLUS_INC !== m_pc + 32'd4) begin fails++; $display("FAIL rand_plus: cycle %0d got %h expected %h", i, bus.PC_PLUS_INC, m_pc + 32'd4); end
      tests++; if (bus.FETCH_VALID !== m_fv) begin fails++; $display("FAIL rand_fv: cycle %0d got %b expected %b", i, bus.FETCH_VALID, m_fv); end
      tests++; if (bus.MISALIGN !== m_mis) begin fails++; $display("FAIL rand_mis: cycle %0d got %b expected %b", i, bus.MISALIGN, m_mis); end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    bus8.BUSYWAIT = 0; bus8.STALL = 0; bus8.BRANCH_TAKEN = 0; bus8.BRANCH_TARGET = 0;
    bus8.TRAP = 0; bus8.TRAP_VECTOR = 0;
    @(posedge clock);
    #1;
    test_reset();
    test_branch();
    test_busywait_branch();
    test_trap_priority();
    test_misalign();
    test_live_beats_pending();
    test_reset_in_hold();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
